// File: rtl/arq_frame_buffer.sv
// arq_frame_buffer: multi-slot stop-and-wait ARQ transmit buffer.
// Whole frames from the mapper are stored in NUM_SLOTS slots and sent in
// order to the line serializer. With ARQ enabled, each sent frame is held
// until ACK, and resent on NACK or timeout until MAX_RETRY resends have been
// used up, after which it is dropped.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing on the line; start the oldest committed frame
// SEND     | streaming mem[rd_slot] word by word to the serializer
// WAIT_ACK | whole frame sent, waiting for ACK/NACK or timeout
module arq_frame_buffer #(
    parameter int DATA_W      = 8,
    parameter int FRAME_LEN   = 16,
    parameter int NUM_SLOTS   = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_RETRY   = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [DATA_W-1:0]            i_frame_data,
    input  logic                         i_frame_valid,
    input  logic                         i_frame_sof,
    output logic                         o_frame_ready,
    output logic [DATA_W-1:0]            o_line_data,
    output logic                         o_line_valid,
    output logic                         o_line_sof,
    input  logic                         i_line_ready,
    input  logic                         i_ack_valid,
    input  logic                         i_ack_good,
    input  logic                         i_arq_en,
    output logic                         o_send_complete,
    output logic                         o_frame_dropped,
    output logic [7:0]                   o_retrans_cnt,
    output logic [$clog2(NUM_SLOTS):0]   o_slots_used
);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int IW = $clog2(FRAME_LEN);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

    logic [DATA_W-1:0] r_mem [NUM_SLOTS][FRAME_LEN];

    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_wr_slot, r_rd_slot;
    logic [IW-1:0]   r_wr_idx, r_rd_idx, w_wr_col;
    logic [TW-1:0]   r_timer;
    logic [RW-1:0]   r_retry;
    logic [SW:0]     r_slots_used;
    logic [7:0]      r_retrans_cnt;
    logic            r_send_complete, r_frame_dropped;

    logic w_wr_acc, w_wr_store, w_commit;
    logic w_done_ok, w_drop, w_retx, w_release;

    assign o_frame_ready   = (r_slots_used < (SW+1)'(NUM_SLOTS));
    assign o_slots_used    = r_slots_used;
    assign o_retrans_cnt   = r_retrans_cnt;
    assign o_send_complete = r_send_complete;
    assign o_frame_dropped = r_frame_dropped;

    // A non-sof word arriving with no open frame is swallowed to resync.
    assign w_wr_acc   = i_frame_valid && o_frame_ready;
    assign w_wr_store = w_wr_acc && (i_frame_sof || (r_wr_idx != '0));
    assign w_commit   = w_wr_acc && !i_frame_sof && (r_wr_idx == LAST_IDX);
    assign w_wr_col   = i_frame_sof ? '0 : r_wr_idx;

    // Frame storage; contents need no reset since slots are tracked by pointers.
    always_ff @(posedge i_clk) begin
        if (w_wr_store)
            r_mem[r_wr_slot][w_wr_col] <= i_frame_data;
    end

    // Write pointers: a sof always restarts the open frame at index 1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_slot <= '0;
            r_wr_idx  <= '0;
        end else if (w_wr_acc) begin
            if (i_frame_sof) begin
                r_wr_idx <= IW'(1);
            end else if (w_commit) begin
                r_wr_idx  <= '0;
                r_wr_slot <= r_wr_slot + SW'(1);
            end else if (r_wr_idx != '0) begin
                r_wr_idx <= r_wr_idx + IW'(1);
            end
        end
    end

    // Tx state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Tx next state, release/retransmit decisions and line outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_done_ok    = 1'b0;
        w_drop       = 1'b0;
        w_retx       = 1'b0;
        o_line_valid = 1'b0;
        o_line_sof   = 1'b0;
        o_line_data  = '0;
        case (r_state)
            IDLE: begin
                if (r_slots_used != '0) w_state_nxt = SEND;
            end
            SEND: begin
                o_line_valid = 1'b1;
                o_line_sof   = (r_rd_idx == '0);
                o_line_data  = r_mem[r_rd_slot][r_rd_idx];
                if (i_line_ready && (r_rd_idx == LAST_IDX)) begin
                    if (i_arq_en) begin
                        w_state_nxt = WAIT_ACK;
                    end else begin
                        w_done_ok   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            WAIT_ACK: begin
                // ACK wins over a coincident timeout; NACK+timeout is one retry.
                if (i_ack_valid && i_ack_good) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = IDLE;
                end else if ((i_ack_valid && !i_ack_good) || (r_timer == TMO_LAST)) begin
                    if (r_retry < RW'(MAX_RETRY)) begin
                        w_retx      = 1'b1;
                        w_state_nxt = SEND;
                    end else begin
                        w_drop      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_release = w_done_ok || w_drop;
    end

    // Read side, ACK timer, retry bookkeeping, occupancy and result pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_slot       <= '0;
            r_rd_idx        <= '0;
            r_timer         <= '0;
            r_retry         <= '0;
            r_slots_used    <= '0;
            r_retrans_cnt   <= '0;
            r_send_complete <= 1'b0;
            r_frame_dropped <= 1'b0;
        end else begin
            r_send_complete <= w_done_ok;
            r_frame_dropped <= w_drop;

            if (r_state != SEND)
                r_rd_idx <= '0;
            else if (i_line_ready)
                r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + IW'(1);

            if (r_state == WAIT_ACK) r_timer <= r_timer + TW'(1);
            else                     r_timer <= '0;

            if (w_release) begin
                r_retry   <= '0;
                r_rd_slot <= r_rd_slot + SW'(1);
            end else if (w_retx) begin
                r_retry <= r_retry + RW'(1);
            end

            if (w_retx && (r_retrans_cnt != 8'hFF))
                r_retrans_cnt <= r_retrans_cnt + 8'd1;

            if (w_commit && !w_release)
                r_slots_used <= r_slots_used + (SW+1)'(1);
            else if (w_release && !w_commit)
                r_slots_used <= r_slots_used - (SW+1)'(1);
        end
    end

endmodule

// File: tb/tb_arq_frame_buffer.sv
// Directed bench for arq_frame_buffer (TIMEOUT_CYC shortened to 64).
module tb_arq_frame_buffer;
    localparam int DATA_W      = 8;
    localparam int FRAME_LEN   = 16;
    localparam int NUM_SLOTS   = 4;
    localparam int TIMEOUT_CYC = 64;
    localparam int MAX_RETRY   = 3;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_frame_data;
    logic        i_frame_valid;
    logic        i_frame_sof;
    logic        o_frame_ready;
    logic [7:0]  o_line_data;
    logic        o_line_valid;
    logic        o_line_sof;
    logic        i_line_ready;
    logic        i_ack_valid;
    logic        i_ack_good;
    logic        i_arq_en;
    logic        o_send_complete;
    logic        o_frame_dropped;
    logic [7:0]  o_retrans_cnt;
    logic [2:0]  o_slots_used;

    arq_frame_buffer #(
        .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .NUM_SLOTS(NUM_SLOTS),
        .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_frame_data(i_frame_data), .i_frame_valid(i_frame_valid),
        .i_frame_sof(i_frame_sof), .o_frame_ready(o_frame_ready),
        .o_line_data(o_line_data), .o_line_valid(o_line_valid),
        .o_line_sof(o_line_sof), .i_line_ready(i_line_ready),
        .i_ack_valid(i_ack_valid), .i_ack_good(i_ack_good),
        .i_arq_en(i_arq_en), .o_send_complete(o_send_complete),
        .o_frame_dropped(o_frame_dropped), .o_retrans_cnt(o_retrans_cnt),
        .o_slots_used(o_slots_used)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    logic [8:0] q_line[$];
    int n_complete = 0;
    int n_dropped  = 0;

    // Record every accepted line word as {sof, data}; count result pulses.
    always @(posedge i_clk) begin
        if (o_line_valid && i_line_ready) q_line.push_back({o_line_sof, o_line_data});
        if (o_send_complete) n_complete <= n_complete + 1;
        if (o_frame_dropped) n_dropped  <= n_dropped + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic put_word(input logic [7:0] d, input logic sof);
        int n;
        n = 0;
        i_frame_data  = d;
        i_frame_sof   = sof;
        i_frame_valid = 1'b1;
        while (!o_frame_ready && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) chk("wr_ready_wait", 32'(o_frame_ready), 32'd1);
        step();
        i_frame_valid = 1'b0;
        i_frame_sof   = 1'b0;
    endtask

    task automatic put_frame(input logic [7:0] base);
        for (int i = 0; i < FRAME_LEN; i++) put_word(8'(base + 8'(i)), (i == 0));
    endtask

    task automatic wait_words(input int target, input string tag);
        int n;
        n = 0;
        while (q_line.size() < target && n < 400) begin
            step();
            n++;
        end
        chk(tag, 32'(q_line.size()), 32'(target));
    endtask

    task automatic check_stream(input int start, input int count, input logic [7:0] base, input string tag);
        logic [8:0] exp;
        for (int i = 0; i < count; i++) begin
            exp = {(i % FRAME_LEN) == 0, 8'(base + 8'(i))};
            chk(tag, 32'(q_line[start + i]), 32'(exp));
        end
    endtask

    task automatic check_repeat(input int start, input int count, input logic [7:0] base, input string tag);
        logic [8:0] exp;
        for (int i = 0; i < count; i++) begin
            exp = {(i % FRAME_LEN) == 0, 8'(base + 8'(i % FRAME_LEN))};
            chk(tag, 32'(q_line[start + i]), 32'(exp));
        end
    endtask

    initial begin
        int qs, cb, db, n;

        i_rst = 1'b1;
        i_frame_data = '0; i_frame_valid = 1'b0; i_frame_sof = 1'b0;
        i_line_ready = 1'b1; i_ack_valid = 1'b0; i_ack_good = 1'b0; i_arq_en = 1'b0;
        #1;
        chk("rst_ready",    32'(o_frame_ready), 32'd1);
        chk("rst_valid",    32'(o_line_valid), 32'd0);
        chk("rst_data",     32'(o_line_data), 32'd0);
        chk("rst_slots",    32'(o_slots_used), 32'd0);
        chk("rst_retrans",  32'(o_retrans_cnt), 32'd0);
        chk("rst_complete", 32'(o_send_complete), 32'd0);
        chk("rst_dropped",  32'(o_frame_dropped), 32'd0);
        step(2);
        i_rst = 1'b0;
        step();

        // Test 1: fire-and-forget, two back-to-back frames.
        qs = q_line.size(); cb = n_complete;
        put_frame(8'h00);
        chk("t1_idle_after_commit", 32'(o_line_valid), 32'd0);
        chk("t1_slots_commit", 32'(o_slots_used), 32'd1);
        put_word(8'h10, 1'b1);
        chk("t1_latency_valid", 32'(o_line_valid), 32'd1);
        chk("t1_latency_sof", 32'(o_line_sof), 32'd1);
        chk("t1_latency_data", 32'(o_line_data), 32'h00);
        for (int i = 1; i < FRAME_LEN; i++) put_word(8'(8'h10 + 8'(i)), 1'b0);
        n = 0;
        while (n_complete < cb + 2 && n < 400) begin step(); n++; end
        chk("t1_complete_cnt", 32'(n_complete - cb), 32'd2);
        chk("t1_word_cnt", 32'(q_line.size() - qs), 32'd32);
        check_stream(qs, 32, 8'h00, "t1_word");
        chk("t1_slots_end", 32'(o_slots_used), 32'd0);

        // Test 2: ARQ, ACK 5 cycles after last word; arq_en change while waiting is ignored.
        i_arq_en = 1'b1;
        qs = q_line.size(); cb = n_complete;
        put_frame(8'h20);
        wait_words(qs + 16, "t2_sent");
        i_arq_en = 1'b0;
        chk("t2_wait_valid", 32'(o_line_valid), 32'd0);
        step(4);
        chk("t2_still_waiting", 32'(o_send_complete), 32'd0);
        chk("t2_slot_held", 32'(o_slots_used), 32'd1);
        i_ack_valid = 1'b1; i_ack_good = 1'b1;
        step();
        i_ack_valid = 1'b0; i_ack_good = 1'b0;
        chk("t2_complete_pulse", 32'(o_send_complete), 32'd1);
        chk("t2_slots_freed", 32'(o_slots_used), 32'd0);
        chk("t2_retrans", 32'(o_retrans_cnt), 32'd0);
        step();
        chk("t2_pulse_width", 32'(o_send_complete), 32'd0);
        step(5);
        chk("t2_sent_once", 32'(q_line.size() - qs), 32'd16);
        check_stream(qs, 16, 8'h20, "t2_word");
        chk("t2_complete_cnt", 32'(n_complete - cb), 32'd1);
        i_arq_en = 1'b1;

        // Test 3: NACK, NACK, ACK.
        qs = q_line.size(); cb = n_complete; db = n_dropped;
        put_frame(8'h30);
        wait_words(qs + 16, "t3_send1");
        step(2);
        i_ack_valid = 1'b1; i_ack_good = 1'b0;
        step();
        i_ack_valid = 1'b0;
        chk("t3_retrans1", 32'(o_retrans_cnt), 32'd1);
        wait_words(qs + 32, "t3_send2");
        i_ack_valid = 1'b1; i_ack_good = 1'b0;
        step();
        i_ack_valid = 1'b0;
        wait_words(qs + 48, "t3_send3");
        i_ack_valid = 1'b1; i_ack_good = 1'b1;
        step();
        i_ack_valid = 1'b0; i_ack_good = 1'b0;
        chk("t3_complete_pulse", 32'(o_send_complete), 32'd1);
        step(3);
        chk("t3_word_cnt", 32'(q_line.size() - qs), 32'd48);
        check_repeat(qs, 48, 8'h30, "t3_word");
        chk("t3_retrans", 32'(o_retrans_cnt), 32'd2);
        chk("t3_complete_cnt", 32'(n_complete - cb), 32'd1);
        chk("t3_dropped_cnt", 32'(n_dropped - db), 32'd0);

        // Test 4: no ACK; resend 64 cycles after each last word, drop after 4 sends.
        qs = q_line.size(); cb = n_complete; db = n_dropped;
        put_frame(8'h40);
        for (int r = 0; r < 3; r++) begin
            wait_words(qs + 16 * (r + 1), "t4_send");
            n = 0;
            do begin step(); n++; end while (!o_line_valid && n < 200);
            chk("t4_resend_gap", 32'(n), 32'd64);
            chk("t4_resend_sof", 32'(o_line_sof), 32'd1);
            chk("t4_resend_data", 32'(o_line_data), 32'h40);
        end
        wait_words(qs + 64, "t4_send4");
        n = 0;
        do begin step(); n++; end while (!o_frame_dropped && n < 200);
        chk("t4_drop_gap", 32'(n), 32'd64);
        chk("t4_slots_freed", 32'(o_slots_used), 32'd0);
        chk("t4_retrans", 32'(o_retrans_cnt), 32'd5);
        step();
        chk("t4_drop_width", 32'(o_frame_dropped), 32'd0);
        chk("t4_no_resend", 32'(o_line_valid), 32'd0);
        chk("t4_dropped_cnt", 32'(n_dropped - db), 32'd1);
        chk("t4_complete_cnt", 32'(n_complete - cb), 32'd0);
        check_repeat(qs, 64, 8'h40, "t4_word");

        // Test 5: line stalled, buffer fills at 4 frames; release re-opens it.
        i_arq_en = 1'b0; i_line_ready = 1'b0;
        qs = q_line.size(); cb = n_complete;
        put_frame(8'h50);
        put_frame(8'h60);
        put_frame(8'h70);
        put_frame(8'h80);
        chk("t5_full_ready", 32'(o_frame_ready), 32'd0);
        chk("t5_full_slots", 32'(o_slots_used), 32'd4);
        chk("t5_hold_data", 32'(o_line_data), 32'h50);
        step(3);
        chk("t5_hold_data2", 32'(o_line_data), 32'h50);
        chk("t5_hold_valid", 32'(o_line_valid), 32'd1);
        chk("t5_hold_sof", 32'(o_line_sof), 32'd1);
        i_line_ready = 1'b1;
        n = 0;
        while (!o_frame_ready && n < 100) begin step(); n++; end
        chk("t5_release_cycles", 32'(n), 32'd16);
        chk("t5_release_slots", 32'(o_slots_used), 32'd3);
        chk("t5_release_pulse", 32'(o_send_complete), 32'd1);
        put_frame(8'h90);
        n = 0;
        while (n_complete < cb + 5 && n < 500) begin step(); n++; end
        chk("t5_complete_cnt", 32'(n_complete - cb), 32'd5);
        chk("t5_word_cnt", 32'(q_line.size() - qs), 32'd80);
        check_stream(qs, 80, 8'h50, "t5_word");
        chk("t5_slots_end", 32'(o_slots_used), 32'd0);

        // Test 6: stray word dropped, partial frame restarted by a sof at word 7.
        qs = q_line.size();
        put_word(8'hEE, 1'b0);
        put_word(8'hA0, 1'b1);
        for (int i = 1; i < 7; i++) put_word(8'(8'hA0 + 8'(i)), 1'b0);
        put_frame(8'hB0);
        wait_words(qs + 16, "t6_sent");
        step(3);
        chk("t6_word_cnt", 32'(q_line.size() - qs), 32'd16);
        check_stream(qs, 16, 8'hB0, "t6_word");
        chk("t6_slots_end", 32'(o_slots_used), 32'd0);

        // Async reset in the middle of SEND.
        i_line_ready = 1'b0;
        put_frame(8'hC0);
        step();
        chk("rst2_in_send", 32'(o_line_valid), 32'd1);
        i_rst = 1'b1;
        #1;
        chk("rst2_valid", 32'(o_line_valid), 32'd0);
        chk("rst2_sof", 32'(o_line_sof), 32'd0);
        chk("rst2_data", 32'(o_line_data), 32'd0);
        chk("rst2_slots", 32'(o_slots_used), 32'd0);
        chk("rst2_retrans", 32'(o_retrans_cnt), 32'd0);
        step();
        i_rst = 1'b0;
        i_line_ready = 1'b1;
        step(4);
        chk("rst2_no_send", 32'(o_line_valid), 32'd0);
        chk("rst2_ready", 32'(o_frame_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
